// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler for the 5-stage core: load-use interlock,
// taken-branch flush, multi-cycle divide hold and a stall-cycle counter.
module hazard_sched_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_MemRead,
    input  logic [4:0]        ex_rd,
    input  logic              ex_div_req,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              load_use_hazard,
    output logic              div_busy,
    output logic              div_done,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PERF_W-1:0]   perf_q;

    logic div_start;
    logic div_run;
    logic div_fin;
    logic lu_hit;
    logic br_sel;
    logic lu_sel;

    // Decode which scheduling case owns this cycle (divide > branch > load-use)
    always_comb begin
        div_start = (state_q == IDLE) && ex_div_req;
        div_run   = (state_q == BUSY) && (cnt_q != '0);
        div_fin   = (state_q == BUSY) && (cnt_q == '0);
        lu_hit    = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
        br_sel    = (state_q == IDLE) && !ex_div_req && ex_branch_taken;
        lu_sel    = (state_q == IDLE) && !ex_div_req && !ex_branch_taken && lu_hit;
    end

    // Stall/flush outputs, all forced low while reset is held
    always_comb begin
        pc_stall        = 1'b0;
        ifid_stall      = 1'b0;
        ifid_flush      = 1'b0;
        idex_stall      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        load_use_hazard = 1'b0;
        div_busy        = 1'b0;
        div_done        = 1'b0;
        perf_stall_cnt  = '0;
        if (!rst) begin
            perf_stall_cnt = perf_q;
            if (div_start || div_run) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
                div_busy    = 1'b1;
            end else if (div_fin) begin
                div_busy = 1'b1;
                div_done = 1'b1;
            end else if (br_sel) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_sel) begin
                pc_stall        = 1'b1;
                ifid_stall      = 1'b1;
                idex_flush      = 1'b1;
                load_use_hazard = 1'b1;
            end
        end
    end

    // Divide sequencer: the start cycle plus DIV_CYCLES-1 BUSY cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_div_req) begin
                        cnt_q   <= CNT_W'(DIV_CYCLES - 2);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (pc_stall && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

endmodule
